// File: rtl/vote_pipe_nway.sv
// Registered N-channel, W-bit bitwise majority/minority voter on a valid/ready stream,
// with per-channel health FSMs. Optional per-channel dissent counters: VOTE_DISSENT_CNT_EN.
module vote_pipe_nway #(
  parameter int N           = 3,
  parameter int W           = 1,
  parameter int DISSENT_LIM = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic [N*W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   fault_mask,
  input  logic           clear_faults,
  output logic [N*8-1:0] dissent_cnt
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  HALF = CW'(N / 2);
  localparam logic [7:0]     LIM  = 8'(DISSENT_LIM);

  typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTED} ch_state_t;

  if ((N < 3) || (N % 2 == 0)) begin : g_bad_n
    $error("vote_pipe_nway: N must be odd and >= 3");
  end
  if (W < 1) begin : g_bad_w
    $error("vote_pipe_nway: W must be >= 1");
  end
  if ((DISSENT_LIM < 2) || (DISSENT_LIM > 255)) begin : g_bad_lim
    $error("vote_pipe_nway: DISSENT_LIM must be in 2..255");
  end

  logic            w_in_xfer;
  logic [CW-1:0]   w_ones;
  logic [W-1:0]    w_maj;
  logic [N-1:0]    w_dissent;

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [N-1:0]    r_fault_mask;
  ch_state_t       r_state [N];
  logic [7:0]      r_cc    [N];

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign fault_mask = r_fault_mask;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_maj  = '0;
    w_ones = '0;
    for (int b = 0; b < W; b++) begin
      w_ones = '0;
      for (int k = 0; k < N; k++) begin
        w_ones = w_ones + CW'(in_data[k*W + b]);
      end
      w_maj[b] = (w_ones > HALF);
    end
  end

  // Dissent is always judged against the majority word, even in minority mode.
  always_comb begin
    w_dissent = '0;
    for (int k = 0; k < N; k++) begin
      w_dissent[k] = (in_data[k*W +: W] != w_maj);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mode ? ~w_maj : w_maj;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // NOTE: the per-channel state arrays are small control registers, so they are reset like any flop.
  always_ff @(posedge clk) begin
    if (reset || clear_faults) begin
      r_fault_mask <= '0;
      for (int k = 0; k < N; k++) begin
        r_state[k] <= HEALTHY;
        r_cc[k]    <= '0;
      end
    end else if (w_in_xfer) begin
      for (int k = 0; k < N; k++) begin
        case (r_state[k])
          HEALTHY: begin
            if (w_dissent[k]) begin
              r_state[k] <= SUSPECT;
              r_cc[k]    <= 8'd1;
            end
          end
          SUSPECT: begin
            if (!w_dissent[k]) begin
              r_state[k] <= HEALTHY;
              r_cc[k]    <= '0;
            end else begin
              r_cc[k] <= r_cc[k] + 8'd1;
              if (r_cc[k] + 8'd1 == LIM) begin
                r_state[k]      <= FAULTED;
                r_fault_mask[k] <= 1'b1;
              end
            end
          end
          FAULTED: ;
          default: r_state[k] <= HEALTHY;
        endcase
      end
    end
  end

`ifdef VOTE_DISSENT_CNT_EN
  logic [7:0] r_dcnt [N];

  always_ff @(posedge clk) begin
    if (reset || clear_faults) begin
      for (int k = 0; k < N; k++) r_dcnt[k] <= '0;
    end else if (w_in_xfer) begin
      for (int k = 0; k < N; k++) begin
        if (w_dissent[k] && (r_dcnt[k] != 8'hFF)) r_dcnt[k] <= r_dcnt[k] + 8'd1;
      end
    end
  end

  always_comb begin
    dissent_cnt = '0;
    for (int k = 0; k < N; k++) dissent_cnt[k*8 +: 8] = r_dcnt[k];
  end
`else
  assign dissent_cnt = '0;
`endif

endmodule

// File: tb/tb_vote_pipe_nway.sv
// Self-checking bench for vote_pipe_nway (N=3, W=4, DISSENT_LIM=4): directed steps then
// random traffic, compared against an arithmetic reference model of the voter and channel health.
module tb_vote_pipe_nway;
  localparam int N   = 3;
  localparam int W   = 4;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           reset, mode, in_valid, out_ready, clear_faults;
  logic [N*W-1:0] in_data;
  logic           in_ready, out_valid;
  logic [W-1:0]   out_data;
  logic [N-1:0]   fault_mask;
  logic [N*8-1:0] dissent_cnt;

  vote_pipe_nway #(.N(N), .W(W), .DISSENT_LIM(LIM)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fault_mask(fault_mask), .clear_faults(clear_faults), .dissent_cnt(dissent_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] exp_data;
  int           cons [N];
  bit           flt  [N];
  int           dcnt [N];
  bit           known = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_maj(logic [N*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      int ones = 0;
      for (int k = 0; k < N; k++) ones += int'(d[k*W + b]);
      r[b] = (2 * ones > N);
    end
    return r;
  endfunction

  function automatic logic [N*8-1:0] exp_cnt();
    logic [N*8-1:0] r;
    r = '0;
`ifdef VOTE_DISSENT_CNT_EN
    for (int k = 0; k < N; k++) r[k*8 +: 8] = 8'(dcnt[k]);
`endif
    return r;
  endfunction

  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = flt[k];
    return r;
  endfunction

  task automatic clear_health();
    for (int k = 0; k < N; k++) begin
      cons[k] = 0; flt[k] = 0; dcnt[k] = 0;
    end
  endtask

  task automatic drive(logic v, logic [N*W-1:0] d, logic m, logic ordy, logic clr, logic rst);
    in_valid = v; in_data = d; mode = m; out_ready = ordy; clear_faults = clr; reset = rst;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    bit xin, xout;
    logic [W-1:0] maj;
    #1;
    if (known && !reset) check("in_ready", in_ready, (q.size() == 0) || out_ready);
    xout = (q.size() != 0) && out_ready;
    xin  = in_valid && ((q.size() == 0) || out_ready);
    maj  = ref_maj(in_data);
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_data = '0;
      clear_health();
      known = 1;
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) begin
        exp_data = mode ? ~maj : maj;
        q.push_back(exp_data);
      end
      if (clear_faults) clear_health();
      else if (xin) begin
        for (int k = 0; k < N; k++) begin
          if (in_data[k*W +: W] != maj) begin
            if (dcnt[k] < 255) dcnt[k]++;
            if (!flt[k]) begin
              cons[k]++;
              if (cons[k] >= LIM) flt[k] = 1;
            end
          end else if (!flt[k]) begin
            cons[k] = 0;
          end
        end
      end
    end
    #1;
    if (known) begin
      check("out_valid", out_valid, q.size() != 0);
      check("out_data", out_data, exp_data);
      check("fault_mask", fault_mask, exp_mask());
      check("dissent_cnt", dissent_cnt, exp_cnt());
    end
  endtask

  initial begin
    logic [W-1:0]   base;
    logic [N*W-1:0] word;
    logic [7:0]     c2;

    // 1. reset for two cycles
    drive(0, '0, 0, 0, 0, 1);
    cycle(); cycle();
    drive(0, '0, 0, 0, 0, 0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fault_mask", fault_mask, 0);
    check("rst_in_ready", in_ready, 1);

    // 2. majority and minority of {F,3,5}
    drive(1, {4'hF, 4'h3, 4'h5}, 0, 1, 0, 0); cycle();
    check("maj_F35", out_data, 4'h7);
    check("maj_F35_valid", out_valid, 1);
    drive(1, {4'hF, 4'h3, 4'h5}, 1, 1, 0, 0); cycle();
    check("min_F35", out_data, 4'h8);

    // 3. backpressure three cycles, then stream without bubbles
    for (int i = 0; i < 3; i++) begin
      drive(1, 12'h123, 0, 0, 0, 0); cycle();
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", out_data, 4'h8);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, N*W'($urandom), $urandom_range(0, 1), 1, 0, 0); cycle();
      check("stream_valid", out_valid, 1);
    end

    // 4. channel 2 faults after four consecutive dissents
    drive(0, '0, 0, 1, 1, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 12'hA00, 0, 1, 0, 0); cycle();
      if (i < 3) check("pre_fault_mask", fault_mask, 3'b000);
    end
    check("fault_ch2", fault_mask, 3'b100);

    // 5. clear while faulted; 3 dissents + agreement never faults; clear beats coincident dissent
    drive(0, '0, 0, 1, 1, 0); cycle();
    check("clear_mask", fault_mask, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive(1, 12'hA00, 0, 1, 0, 0); cycle();
    end
    drive(1, 12'h000, 0, 1, 0, 0); cycle();
    drive(1, 12'hA00, 0, 1, 0, 0); cycle();
    drive(1, 12'hA00, 0, 1, 0, 0); cycle();
    drive(1, 12'hA00, 0, 1, 1, 0); cycle();
    drive(1, 12'hA00, 0, 1, 0, 0); cycle();
    check("no_fault_after_agree", fault_mask, 3'b000);

    drive(0, '0, 0, 1, 1, 0); cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1, 12'hA00, 0, 1, 0, 0); cycle();
    end
    c2 = dissent_cnt[23:16];
`ifdef VOTE_DISSENT_CNT_EN
    check("cnt_saturated", c2, 8'd255);
`else
    check("cnt_tied_zero", c2, 8'd0);
`endif
    drive(0, '0, 0, 1, 1, 0); cycle();
    check("cnt_cleared", dissent_cnt, '0);

    // 6. reset while an output word is stalled
    drive(1, 12'h5A3, 0, 0, 0, 0); cycle();
    check("stall_valid", out_valid, 1);
    drive(0, '0, 0, 0, 0, 1); cycle();
    check("rst_drop_valid", out_valid, 0);
    drive(1, 12'hFF0, 0, 1, 0, 0); cycle();
    check("post_rst_vote", out_data, 4'hF);

    // Random traffic with mostly-agreeing channels
    for (int i = 0; i < 600; i++) begin
      base = W'($urandom);
      for (int k = 0; k < N; k++)
        word[k*W +: W] = ($urandom_range(0, 9) < 7) ? base : W'($urandom);
      drive($urandom_range(0, 3) != 0, word, $urandom_range(0, 1),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
      cycle();
    end

    drive(0, '0, 0, 1, 0, 0); cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
